// File: rtl/movimento_cornice_pkg.sv
// movimento_cornice_pkg
//   Shared definitions for the on-screen shape motion controller: visible
//   screen size (also used by the VGA timing generator), the motion FSM state
//   encoding and the per-axis step mode.
package movimento_cornice_pkg;

  // Visible screen geometry in pixels / lines.
  localparam int H_VIS = 1280;
  localparam int V_VIS = 1024;

  // Motion FSM states, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WAIT_FRAME = 3'd1;
  localparam state_t ST_STEP_X     = 3'd2;
  localparam state_t ST_STEP_Y     = 3'd3;
  localparam state_t ST_COMMIT     = 3'd4;

  // How an axis treats its limits: wrap around (modulo) or reflect.
  typedef enum logic {
    MODE_WRAP   = 1'b0,
    MODE_BOUNCE = 1'b1
  } axis_mode_e;

endpackage

// File: rtl/movimento_cornice_passo_asse.sv
// passo_asse
//   Combinational single-axis step for the shape centre.
//   pos      : current centre coordinate
//   step     : pixels to move this frame
//   dir      : 1 = towards increasing coordinate
//   mode     : MODE_WRAP (modulo hi+1, lo ignored) or MODE_BOUNCE (clamp + flip)
//   lo, hi   : inclusive limits of the legal range
//   next_pos : coordinate after the step, always within lo..hi
//   flip     : direction must reverse (bounce mode only)
module passo_asse
  import movimento_cornice_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0] pos,
  input  logic [3:0]   step,
  input  logic         dir,
  input  axis_mode_e   mode,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic [W-1:0] next_pos,
  output logic         flip
);

  // One extra bit so pos+step and pos+modulus never overflow.
  logic [W:0] pos_x;
  logic [W:0] step_x;
  logic [W:0] lo_x;
  logic [W:0] hi_x;
  logic [W:0] up_sum;
  logic [W:0] modulus;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    next_pos = pos;
    flip     = 1'b0;

    pos_x   = {1'b0, pos};
    step_x  = {{(W-3){1'b0}}, step};
    lo_x    = {1'b0, lo};
    hi_x    = {1'b0, hi};
    up_sum  = pos_x + step_x;
    modulus = hi_x + 1'b1;

    if (mode == MODE_WRAP) begin
      if (dir) begin
        next_pos = (up_sum > hi_x) ? W'(up_sum - modulus) : W'(up_sum);
      end else begin
        next_pos = (pos_x < step_x) ? W'(pos_x + modulus - step_x)
                                    : W'(pos_x - step_x);
      end
    end else begin
      if (dir) begin
        if (up_sum > hi_x) begin
          next_pos = hi;
          flip     = 1'b1;
        end else begin
          next_pos = W'(up_sum);
        end
      end else begin
        if (pos_x < lo_x + step_x) begin
          next_pos = lo;
          flip     = 1'b1;
        end else begin
          next_pos = W'(pos_x - step_x);
        end
      end
    end
  end

endmodule

// File: rtl/movimento_cornice.sv
// movimento_cornice
//   Per-frame motion controller for the rectangle/frame shape. On each frame
//   tick it steps the centre horizontally (wrapping) and vertically
//   (bouncing off top/bottom), then commits both coordinates together.
//   CLK          : pixel clock
//   RST_N        : synchronous active-low reset
//   FRAME_TICK   : one-cycle pulse at start of vertical blanking
//   ENABLE       : motion enable
//   SPEED        : pixels per frame, both axes, sampled on the accepted tick
//   X_POS, Y_POS : registered shape centre
//   UPDATE_DONE  : one-cycle pulse when a new position is committed
//   BOUNCE_COUNT : vertical bounces, wrapping 255->0
//   OVERRUN      : sticky, a tick arrived while an update was in flight
module movimento_cornice
  import movimento_cornice_pkg::*;
#(
  parameter int H         = H_VIS,
  parameter int V         = V_VIS,
  parameter int altezza   = 100,
  parameter int larghezza = 100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FRAME_TICK,
  input  logic        ENABLE,
  input  logic [3:0]  SPEED,
  output logic [10:0] X_POS,
  output logic [10:0] Y_POS,
  output logic        UPDATE_DONE,
  output logic [7:0]  BOUNCE_COUNT,
  output logic        OVERRUN
);

  localparam int          ALT2   = altezza / 2;
  localparam logic [10:0] X_LO   = 11'd0;
  localparam logic [10:0] X_HI   = 11'(H - 1);
  localparam logic [10:0] Y_LO   = 11'(ALT2);
  localparam logic [10:0] Y_HI   = 11'(V - 1 - ALT2);
  localparam logic [10:0] X_INIT = 11'(H / 2);
  localparam logic [10:0] Y_INIT = 11'(V / 2);

  // Shape must fit on screen for the bounce limits to make sense.
  if (larghezza > H || altezza > V) begin : g_param_check
    $error("movimento_cornice: shape larger than the screen");
  end

  state_t      state_q,  state_d;
  logic [3:0]  step_q,   step_d;
  logic [10:0] x_pos_q,  x_pos_d;
  logic [10:0] y_pos_q,  y_pos_d;
  logic [10:0] x_nxt_q,  x_nxt_d;
  logic [10:0] y_nxt_q,  y_nxt_d;
  logic        dir_x_q,  dir_x_d;
  logic        dir_y_q,  dir_y_d;
  logic [7:0]  bounce_q, bounce_d;
  logic        overrun_q, overrun_d;
  logic        done_q,   done_d;

  logic [10:0] x_step_pos;
  logic [10:0] y_step_pos;
  logic        x_flip;
  logic        y_flip;

  passo_asse #(.W(11)) u_passo_x (
    .pos      (x_pos_q),
    .step     (step_q),
    .dir      (dir_x_q),
    .mode     (MODE_WRAP),
    .lo       (X_LO),
    .hi       (X_HI),
    .next_pos (x_step_pos),
    .flip     (x_flip)
  );

  passo_asse #(.W(11)) u_passo_y (
    .pos      (y_pos_q),
    .step     (step_q),
    .dir      (dir_y_q),
    .mode     (MODE_BOUNCE),
    .lo       (Y_LO),
    .hi       (Y_HI),
    .next_pos (y_step_pos),
    .flip     (y_flip)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    x_pos_d   = x_pos_q;
    y_pos_d   = y_pos_q;
    x_nxt_d   = x_nxt_q;
    y_nxt_d   = y_nxt_q;
    dir_x_d   = dir_x_q;   // horizontal direction is fixed after reset
    dir_y_d   = dir_y_q;
    bounce_d  = bounce_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        // Dropping ENABLE wins over a coincident tick.
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (FRAME_TICK) begin
          step_d  = SPEED;
          state_d = ST_STEP_X;
        end
      end
      ST_STEP_X: begin
        x_nxt_d = x_step_pos;
        state_d = ST_STEP_Y;
        if (FRAME_TICK) overrun_d = 1'b1;
      end
      ST_STEP_Y: begin
        y_nxt_d = y_step_pos;
        if (y_flip) begin
          dir_y_d  = ~dir_y_q;
          bounce_d = bounce_q + 8'd1;
        end
        state_d = ST_COMMIT;
        if (FRAME_TICK) overrun_d = 1'b1;
      end
      ST_COMMIT: begin
        // Both coordinates land on the same edge so the hit-test never sees
        // a mixed old/new pair.
        x_pos_d = x_nxt_q;
        y_pos_d = y_nxt_q;
        done_d  = 1'b1;
        state_d = ENABLE ? ST_WAIT_FRAME : ST_IDLE;
        if (FRAME_TICK) overrun_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: the scratch x/y_nxt registers are reset too, so nothing depends
    // on power-up contents; sequential state uses non-blocking assignments
    // only, so all flops sample the same pre-edge values.
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      step_q    <= 4'd0;
      x_pos_q   <= X_INIT;
      y_pos_q   <= Y_INIT;
      x_nxt_q   <= X_INIT;
      y_nxt_q   <= Y_INIT;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      bounce_q  <= 8'd0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      x_pos_q   <= x_pos_d;
      y_pos_q   <= y_pos_d;
      x_nxt_q   <= x_nxt_d;
      y_nxt_q   <= y_nxt_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      bounce_q  <= bounce_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  assign X_POS        = x_pos_q;
  assign Y_POS        = y_pos_q;
  assign UPDATE_DONE  = done_q;
  assign BOUNCE_COUNT = bounce_q;
  assign OVERRUN      = overrun_q;

  // x_flip is structurally always 0 in wrap mode.
  logic unused_x_flip;
  assign unused_x_flip = x_flip;

endmodule
